// File: rtl/ook_packet_tx.sv
// On-off-keying packet transmitter: one sync chip, PWM-coded data, gap, repeated REPEATS times.
// Define OOK_ABORT_EN to add an `abort` input that cancels a transmission in progress.
module ook_packet_tx #(
  parameter int DATA_BITS      = 24,
  parameter int CHIP_CYCLES    = 4000,
  parameter int SYNC_LOW_CHIPS = 10,
  parameter int GAP_CHIPS      = 30,
  parameter int REPEATS        = 6
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef OOK_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 cmd_valid,
  input  logic [DATA_BITS-1:0] cmd_data,
  output logic                 cmd_ready,
  output logic                 ook,
  output logic                 busy,
  output logic                 packet_start,
  output logic                 done
);

  localparam int TW      = (CHIP_CYCLES > 1) ? $clog2(CHIP_CYCLES) : 1;
  localparam int BW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int RW      = (REPEATS > 1) ? $clog2(REPEATS) : 1;
  localparam int CNT_MAX = (SYNC_LOW_CHIPS > GAP_CHIPS) ? SYNC_LOW_CHIPS : GAP_CHIPS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SYNC_HI, SYNC_LO, DATA, GAP} state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           phase_q, phase_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [RW-1:0]        rep_q, rep_d;
  logic [DATA_BITS-1:0] word_q, word_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ook_q, ook_d;
  logic                 packet_start_q, packet_start_d;
  logic                 done_q, done_d;
  logic                 chip_end;

  assign cmd_ready    = (state_q == IDLE) && !reset;
  assign busy         = (state_q != IDLE);
  assign ook          = ook_q;
  assign packet_start = packet_start_q;
  assign done         = done_q;
  assign chip_end     = (timer_q == '0);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d        = state_q;
    timer_d        = timer_q;
    cnt_d          = cnt_q;
    phase_d        = phase_q;
    bit_d          = bit_q;
    rep_d          = rep_q;
    word_d         = word_q;
    shift_d        = shift_q;
    ook_d          = ook_q;
    packet_start_d = 1'b0;
    done_d         = 1'b0;

    if (state_q == IDLE) begin
      if (cmd_valid) begin
        word_d         = cmd_data;
        shift_d        = cmd_data;
        rep_d          = RW'(REPEATS - 1);
        timer_d        = TW'(CHIP_CYCLES - 1);
        state_d        = SYNC_HI;
        ook_d          = 1'b1;
        packet_start_d = 1'b1;
      end
    end else if (!chip_end) begin
      timer_d = timer_q - 1'b1;
    end else begin
      // ook_d is the level of the chip being entered, so ook only moves on chip boundaries.
      timer_d = TW'(CHIP_CYCLES - 1);
      case (state_q)
        SYNC_HI: begin
          state_d = SYNC_LO;
          cnt_d   = CW'(SYNC_LOW_CHIPS - 1);
          ook_d   = 1'b0;
        end
        SYNC_LO: begin
          if (cnt_q == '0) begin
            state_d = DATA;
            bit_d   = BW'(DATA_BITS - 1);
            phase_d = 2'd0;
            ook_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DATA: begin
          case (phase_q)
            2'd0: begin
              phase_d = 2'd1;
              ook_d   = shift_q[DATA_BITS-1];
            end
            2'd1: begin
              phase_d = 2'd2;
              ook_d   = 1'b0;
            end
            default: begin
              if (bit_q == '0) begin
                state_d = GAP;
                cnt_d   = CW'(GAP_CHIPS - 1);
                ook_d   = 1'b0;
              end else begin
                bit_d   = bit_q - 1'b1;
                phase_d = 2'd0;
                shift_d = shift_q << 1;
                ook_d   = 1'b1;
              end
            end
          endcase
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (rep_q != '0) begin
            rep_d          = rep_q - 1'b1;
            shift_d        = word_q;
            state_d        = SYNC_HI;
            ook_d          = 1'b1;
            packet_start_d = 1'b1;
          end else begin
            state_d = IDLE;
            timer_d = '0;
            ook_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef OOK_ABORT_EN
    if (abort && (state_q != IDLE)) begin
      state_d        = IDLE;
      timer_d        = '0;
      cnt_d          = '0;
      phase_d        = '0;
      bit_d          = '0;
      rep_d          = '0;
      shift_d        = '0;
      ook_d          = 1'b0;
      packet_start_d = 1'b0;
      done_d         = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      cnt_q          <= '0;
      phase_q        <= '0;
      bit_q          <= '0;
      rep_q          <= '0;
      word_q         <= '0;
      shift_q        <= '0;
      ook_q          <= 1'b0;
      packet_start_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      cnt_q          <= cnt_d;
      phase_q        <= phase_d;
      bit_q          <= bit_d;
      rep_q          <= rep_d;
      word_q         <= word_d;
      shift_q        <= shift_d;
      ook_q          <= ook_d;
      packet_start_q <= packet_start_d;
      done_q         <= done_d;
    end
  end

endmodule
